// File: rtl/xor_serial_arb_v.sv
// ---------------------------------------------------------------------------
// xor_serial_arb_v
//
// Two-requester, round-robin arbitrated bit-serial XOR engine. The winning
// requester's operands are captured on the grant edge. They are then pushed
// LSB-first through a single shared 1-bit XOR2 cell, one bit per clock. The
// full result appears after WIDTH shift cycles. One operation completes every
// WIDTH+2 cycles.
//
// Ports
//   i_clk              clock, all state on the rising edge
//   i_rst              synchronous active-high reset
//   i_req0 / i_req1    level requests, held until granted
//   i_a0, i_b0         requester 0 operands
//   i_a1, i_b1         requester 1 operands
//   o_gnt0 / o_gnt1    one-cycle grant pulses (operands captured)
//   o_busy             high while the engine is not idle
//   o_result           A ^ B of the last completed operation (held)
//   o_valid            one-cycle pulse when o_result/o_owner update
//   o_owner            requester index of the last completed operation
// ---------------------------------------------------------------------------

// Team 1-bit XOR2 cell, the only XOR in the datapath.
module XOR2_v (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module xor_serial_arb_v #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_a0,
    input  logic [WIDTH-1:0] i_b0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic             o_gnt0,
    output logic             o_gnt1,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_result,
    output logic             o_valid,
    output logic             o_owner
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_q, last_d;     // requester served most recently
    logic             cur_q, cur_d;       // requester of the running operation
    logic             owner_q, owner_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    logic             xor_bit;
    logic             winner;
    logic [WIDTH-1:0] acc_next;

    XOR2_v u_xor2 (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .y (xor_bit)
    );

    // Result bits enter at the MSB end, so after WIDTH shifts bit 0 of the
    // operands has travelled down to bit 0 of the accumulator.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_next = xor_bit;
        end else begin : g_acc_wn
            assign acc_next = {xor_bit, acc_q[WIDTH-1:1]};
        end
    endgenerate

    // On a tie the requester that was not served last wins; a single
    // request always wins.
    assign winner = (i_req0 && i_req1) ? ~last_q : i_req1;

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        cur_d    = cur_q;
        owner_d  = owner_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        valid_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    state_d = SHIFT;
                    a_sh_d  = winner ? i_a1 : i_a0;
                    b_sh_d  = winner ? i_b1 : i_b0;
                    cnt_d   = '0;
                    last_d  = winner;
                    cur_d   = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                end
            end
            SHIFT: begin
                acc_d  = acc_next;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d  = DONE;
                    result_d = acc_next;
                    owner_d  = cur_q;
                    valid_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b1;    // requester 0 wins the first tie
            cur_q    <= 1'b0;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            cur_q    <= cur_d;
            owner_q  <= owner_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign o_gnt0   = gnt0_q;
    assign o_gnt1   = gnt1_q;
    assign o_busy   = busy_q;
    assign o_result = result_q;
    assign o_valid  = valid_q;
    assign o_owner  = owner_q;

endmodule

// File: doc/xor_serial_arb_v.md
XOR_SERIAL_ARB_V -- requirements
Module: xor_serial_arb_v

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: i_rst  in  1  synchronous, active-high reset.
REQ-004 Port: i_req0  in  1  requester 0 operation request, level, held until granted.
REQ-005 Port: i_a0  in  WIDTH  requester 0 operand A.
REQ-006 Port: i_b0  in  WIDTH  requester 0 operand B.
REQ-007 Port: i_req1  in  1  requester 1 operation request, level, held until granted.
REQ-008 Port: i_a1  in  WIDTH  requester 1 operand A.
REQ-009 Port: i_b1  in  WIDTH  requester 1 operand B.
REQ-010 Port: o_gnt0  out  1  one-cycle pulse; requester 0 operands captured.
REQ-011 Port: o_gnt1  out  1  one-cycle pulse; requester 1 operands captured.
REQ-012 Port: o_busy  out  1  high while state is not IDLE.
REQ-013 Port: o_result  out  WIDTH  bitwise A XOR B of the last completed operation.
REQ-014 Port: o_valid  out  1  one-cycle pulse; o_result/o_owner are new.
REQ-015 Port: o_owner  out  1  requester index of the last completed operation.

Function
REQ-016 Datapath SHALL be one instance of the team's 1-bit XOR2 cell (XOR2_v), time-shared; no WIDTH-wide XOR.
REQ-017 FSM states SHALL be IDLE, SHIFT, DONE; all outputs registered.
REQ-018 IDLE: on an edge with any request high -> SHIFT; winner's A/B loaded into shift registers, bit counter = 0, matching o_gntN = 1 for the following cycle only.
REQ-019 IDLE, no request -> stay IDLE; o_gnt0/o_gnt1 = 0.
REQ-020 Arbitration SHALL be round-robin: single request wins; both high -> grant the requester not served last; last-served pointer updates only on grant.
REQ-021 SHIFT: each edge feeds the LSBs of A/B through the XOR2 cell, shifts the result bit into result register at MSB end, shifts A/B right, increments counter.
REQ-022 SHIFT -> DONE on the edge processing bit WIDTH-1; at that edge o_result = full result, o_owner = winner, o_valid = 1.
REQ-023 DONE -> IDLE on next edge unconditionally; o_valid returns to 0.
REQ-024 Latency: grant sampled at edge E0; o_valid high in cycle after edge E(WIDTH); next grant earliest at edge E(WIDTH+2); throughput one op per WIDTH+2 cycles.
REQ-025 Requests while busy SHALL be ignored, not queued; a request still held on return to IDLE is arbitrated then.
REQ-026 Request withdrawn before grant SHALL never be granted.
REQ-027 Operand inputs sampled only at grant edge; later changes SHALL not affect the running operation.
REQ-028 o_result and o_owner SHALL hold their value between completions (not cleared on grant).
REQ-029 o_gnt0 and o_gnt1 SHALL never be high in the same cycle.

Reset
REQ-030 i_rst high at an edge SHALL force IDLE, counter 0, shift registers 0, o_gnt0/o_gnt1/o_busy/o_valid/o_owner = 0, o_result = 0, last-served = 1 (requester 0 wins first tie).
REQ-031 Reset SHALL take priority over all requests and state transitions, including mid-SHIFT; aborted operation SHALL produce no o_valid.

Verification
REQ-032 Reset, then i_req0=1, i_a0=0xA5, i_b0=0x0F -> o_gnt0 pulse 1 cycle after sampling edge; o_valid 8 cycles after gnt cycle, o_result=0xAA, o_owner=0, o_busy high 9 cycles.
REQ-033 Reset, both requests at same edge: A0=0xFF,B0=0x00; A1=0x3C,B1=0x3C -> first op owner 0 result 0xFF, second op owner 1 result 0x00, second o_gnt1 exactly 10 cycles after o_gnt0.
REQ-034 Both requests held continuously for 4 operations -> o_owner sequence 0,1,0,1; never two gnts same cycle.
REQ-035 Reset asserted on 3rd SHIFT cycle of op 0x12^0x34 -> all outputs 0 next cycle, no o_valid; subsequent op 0x12^0x34 gives 0x26.
REQ-036 i_req1 pulsed for 2 cycles while busy then dropped -> o_gnt1 never asserted; i_a0 changed mid-SHIFT -> result unaffected.
REQ-037 WIDTH=1 build: exhaustive 4 operand pairs -> results 0,1,1,0, o_valid 1 cycle after gnt cycle.
